obstacle_map_gen: RTL and testbench

//  Upstream feeder for the physics engine (Brain). Generates the scrolling 16-bit obstacle map: 8 columns x 2 bits.

---
 rtl/game_pkg.sv | 24 ++
 rtl/obstacle_map_gen_lfsr16.sv | 29 ++
 rtl/obstacle_map_gen.sv | 131 +++++++++++++
 tb/tb_obstacle_map_gen.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the obstacle generator and Brain: column codes,
// generator states and the 16-bit Fibonacci LFSR step.
package game_pkg;

    localparam int MAP_W = 16;

    localparam logic [1:0] COL_EMPTY  = 2'b00;
    localparam logic [1:0] COL_GROUND = 2'b01;
    localparam logic [1:0] COL_HIGH   = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } state_t;

    // Feedback taps at bits 15, 13, 12 and 10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_advance(input logic [15:0] v);
        return {v[14:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/obstacle_map_gen_lfsr16.sv
// 16-bit Fibonacci LFSR; load returns to the seed and wins over adv.
module lfsr16
    import game_pkg::*;
#(
    parameter logic [15:0] INIT = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        adv,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    logic [15:0] lfsr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= INIT;
        end else if (load) begin
            lfsr_reg <= seed;
        end else if (adv) begin
            lfsr_reg <= lfsr_advance(lfsr_reg);
        end
    end

    assign q = lfsr_reg;

endmodule

// File: rtl/obstacle_map_gen.sv
// Scrolling 8-column obstacle map with gap-guaranteed random spawns,
// freeze on death and a step period that shrinks as obstacles are passed.
module obstacle_map_gen
    import game_pkg::*;
#(
    parameter int          STEP_DIV      = 25_000_000,
    parameter int          MIN_DIV       = 4_000_000,
    parameter int          MIN_GAP       = 2,
    parameter int          SPEEDUP_EVERY = 8,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_dead,
    output logic [MAP_W-1:0] map,
    output logic             step,
    output logic [7:0]       passed
);

    localparam int DW = $clog2(STEP_DIV + 1);
    localparam int GW = $clog2(MIN_GAP + 1);

    state_t           state_reg;
    logic [MAP_W-1:0] map_reg;
    logic             step_reg;
    logic [7:0]       passed_reg;
    logic [GW-1:0]    gap_reg;
    logic [DW-1:0]    div_reg;
    logic [DW-1:0]    tick_reg;

    logic [15:0]   lfsr_q;
    logic [15:0]   lfsr_l;
    logic          lfsr_unused;
    logic          lfsr_load;
    logic          tick_done;
    logic [1:0]    col_next;
    logic [GW-1:0] gap_next;
    logic          passed_inc;
    logic [7:0]    passed_next;
    logic          speed_up;
    logic [DW-1:0] div_dec;
    logic [DW-1:0] div_next;

    assign tick_done = (state_reg == RUN) && !is_dead && (tick_reg == div_reg - DW'(1));
    assign lfsr_load = (state_reg == IDLE) || ((state_reg == FROZEN) && !start);

    lfsr16 #(.INIT(SEED)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (lfsr_load),
        .adv   (tick_done),
        .seed  (SEED),
        .q     (lfsr_q)
    );

    // Spawn decisions use the value the LFSR takes at this step's edge.
    assign lfsr_l      = lfsr_advance(lfsr_q);
    assign lfsr_unused = ^{lfsr_l[15:4], lfsr_l[1:0]};

    always_comb begin
        col_next = COL_EMPTY;
        gap_next = gap_reg;
        if (gap_reg != '0) begin
            gap_next = gap_reg - GW'(1);
        end else if (lfsr_l[2]) begin
            col_next = lfsr_l[3] ? COL_HIGH : COL_GROUND;
            gap_next = GW'(MIN_GAP);
        end
    end

    assign passed_inc  = (map_reg[MAP_W-1 -: 2] != COL_EMPTY) && (passed_reg != 8'hFF);
    assign passed_next = passed_reg + 8'd1;
    assign speed_up    = passed_inc && ((int'(passed_next) % SPEEDUP_EVERY) == 0);
    assign div_dec     = div_reg - (div_reg >> 3);
    assign div_next    = (div_dec < DW'(MIN_DIV)) ? DW'(MIN_DIV) : div_dec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            map_reg    <= '0;
            step_reg   <= 1'b0;
            passed_reg <= '0;
            gap_reg    <= '0;
            div_reg    <= DW'(STEP_DIV);
            tick_reg   <= '0;
        end else begin
            step_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    map_reg    <= '0;
                    passed_reg <= '0;
                    gap_reg    <= '0;
                    div_reg    <= DW'(STEP_DIV);
                    tick_reg   <= '0;
                    if (start) state_reg <= RUN;
                end
                RUN: begin
                    if (is_dead) begin
                        state_reg <= FROZEN;
                    end else if (tick_done) begin
                        tick_reg <= '0;
                        step_reg <= 1'b1;
                        map_reg  <= {map_reg[MAP_W-3:0], col_next};
                        gap_reg  <= gap_next;
                        if (passed_inc) passed_reg <= passed_next;
                        if (speed_up)   div_reg    <= div_next;
                    end else begin
                        tick_reg <= tick_reg + DW'(1);
                    end
                end
                FROZEN: begin
                    if (!start) begin
                        state_reg  <= IDLE;
                        map_reg    <= '0;
                        passed_reg <= '0;
                        gap_reg    <= '0;
                        div_reg    <= DW'(STEP_DIV);
                        tick_reg   <= '0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign map    = map_reg;
    assign step   = step_reg;
    assign passed = passed_reg;

endmodule

// File: tb/tb_obstacle_map_gen.sv
// Directed/randomized bench for obstacle_map_gen against a column-array model
// of the game rules; one DUT with period 4, one with period 64.
module tb_obstacle_map_gen;

    localparam int          SD_A  = 4;
    localparam int          SD_B  = 64;
    localparam int          MD    = 2;
    localparam int          GAP   = 2;
    localparam int          SPE   = 8;
    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          BOUND = 500;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, dead_a = 1'b0;
    logic        start_b = 1'b0, dead_b = 1'b0;
    logic [15:0] map_a, map_b;
    logic        step_a, step_b;
    logic [7:0]  passed_a, passed_b;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    obstacle_map_gen #(.STEP_DIV(SD_A), .MIN_DIV(MD), .MIN_GAP(GAP),
                       .SPEEDUP_EVERY(SPE), .SEED(SEED)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .is_dead(dead_a),
        .map(map_a), .step(step_a), .passed(passed_a)
    );

    obstacle_map_gen #(.STEP_DIV(SD_B), .MIN_DIV(MD), .MIN_GAP(GAP),
                       .SPEEDUP_EVERY(SPE), .SEED(SEED)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .is_dead(dead_b),
        .map(map_b), .step(step_b), .passed(passed_b)
    );

    // Reference model: columns as an array, index 0 newest, 7 at the player.
    logic [15:0] m_lfsr;
    int          m_gap, m_passed, m_div;
    int          m_cols [8];

    task automatic mdl_reset(input int d0);
        m_lfsr = SEED; m_gap = 0; m_passed = 0; m_div = d0;
        for (int i = 0; i < 8; i++) m_cols[i] = 0;
    endtask

    task automatic mdl_step();
        logic fb;
        int   nc;
        fb = m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10];
        m_lfsr = {m_lfsr[14:0], fb};
        if (m_gap > 0) begin
            nc = 0; m_gap = m_gap - 1;
        end else if (m_lfsr[2] == 1'b0) begin
            nc = 0;
        end else begin
            nc = m_lfsr[3] ? 2 : 1; m_gap = GAP;
        end
        if (m_cols[7] != 0 && m_passed < 255) begin
            m_passed = m_passed + 1;
            if (m_passed % SPE == 0) begin
                m_div = m_div - m_div / 8;
                if (m_div < MD) m_div = MD;
            end
        end
        for (int i = 7; i > 0; i--) m_cols[i] = m_cols[i-1];
        m_cols[0] = nc;
    endtask

    function automatic logic [15:0] mdl_map();
        logic [15:0] r = '0;
        for (int i = 0; i < 8; i++) r = r | (16'(m_cols[i]) << (2 * i));
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    endtask

    // Wait for the next step pulse, advance the model, compare everything.
    task automatic do_step(input bit use_b, input string tag);
        int   cnt = 0;
        int   exp_int;
        logic st;
        exp_int = m_div;
        do begin
            @(negedge clk);
            cnt++;
            st = use_b ? step_b : step_a;
        end while (st !== 1'b1 && cnt < BOUND);
        mdl_step();
        chk({tag, " period"}, cnt, exp_int);
        chk({tag, " map"}, use_b ? map_b : map_a, mdl_map());
        chk({tag, " passed"}, use_b ? passed_b : passed_a, m_passed);
        chk({tag, " lfsr"}, use_b ? dut_b.lfsr_q : dut_a.lfsr_q, m_lfsr);
        if (cnt >= BOUND) finish_run();
    endtask

    initial begin
        mdl_reset(SD_A);
        #1;
        chk("rst map", map_a, 16'h0);
        chk("rst step", step_a, 1'b0);
        chk("rst passed", passed_a, 8'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle map", map_a, 16'h0);

        // First steps of the game from the seed.
        start_a = 1'b1;
        @(negedge clk);
        do_step(1'b0, "s1");
        chk("s1 lfsr const", dut_a.lfsr_q, 16'h59C3);
        do_step(1'b0, "s2");
        chk("s2 map const", map_a, 16'h0001);
        do_step(1'b0, "s3");
        do_step(1'b0, "s4");

        // Death lands on the cycle whose edge would expire the tick.
        repeat (3) @(negedge clk);
        dead_a = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("frz step", step_a, 1'b0);
            chk("frz map", map_a, mdl_map());
            chk("frz passed", passed_a, m_passed);
        end
        dead_a = 1'b0;
        start_a = 1'b0;
        @(negedge clk);
        chk("idle2 map", map_a, 16'h0);
        chk("idle2 passed", passed_a, 8'h0);

        start_a = 1'b1;
        mdl_reset(SD_A);
        @(negedge clk);
        do_step(1'b0, "r1");
        chk("r1 lfsr const", dut_a.lfsr_q, 16'h59C3);
        do_step(1'b0, "r2");
        chk("r2 map const", map_a, 16'h0001);

        // Random start level while running must not affect the run.
        for (int i = 0; i < 400 && m_passed < 10; i++) begin
            do_step(1'b0, "run");
            start_a = 1'($urandom_range(0, 1));
        end
        chk("run passed10", passed_a, 8'd10);

        // Async reset between ticks, in the cycle the step pulse is high.
        #2 rst_n = 1'b0;
        #1;
        chk("arst map", map_a, 16'h0);
        chk("arst step", step_a, 1'b0);
        chk("arst passed", passed_a, 8'h0);
        @(negedge clk);
        rst_n = 1'b1;
        start_a = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("post-rst step", step_a, 1'b0);
            chk("post-rst map", map_a, 16'h0);
        end

        // Long run to saturation of the passed counter.
        start_a = 1'b1;
        mdl_reset(SD_A);
        @(negedge clk);
        for (int i = 0; i < 3000 && m_passed < 255; i++) begin
            do_step(1'b0, "sat");
            start_a = 1'($urandom_range(0, 1));
        end
        for (int i = 0; i < 20; i++) do_step(1'b0, "sat-hold");
        chk("sat passed", passed_a, 8'd255);
        dead_a = 1'b1;

        // Larger period: speed-ups at 8 and 16 passed obstacles.
        mdl_reset(SD_B);
        start_b = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 400 && m_passed < 17; i++) begin
            do_step(1'b1, "d64");
            start_b = 1'($urandom_range(0, 1));
        end
        do_step(1'b1, "d64-last");

        finish_run();
    end

endmodule
